// File: rtl/dma_burst_target.sv
// dma_burst_target: burst responder sinking/sourcing beats to an internal word memory.
// Optional ADDR_RANGE_CHK_EN: out-of-range bursts are handshaked but masked and report err.
module dma_burst_target #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int BURST_LEN = 4,
  parameter int MEM_DEPTH = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [BURST_LEN-1:0]  req_len,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  input  logic                  rready,
  output logic                  done,
  output logic                  err
);
  localparam int OFF = $clog2(DATA_WIDTH / 8);
  localparam int IW = $clog2(MEM_DEPTH);
  localparam logic [IW-1:0] I1 = 1;
  localparam logic [BURST_LEN-1:0] C1 = 1;
  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;
  state_t state, nxt;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [IW-1:0] idx, start;
  logic [BURST_LEN-1:0] cnt, len;
  logic bad, bad_q, acc, wbeat, rbeat, last;
  assign start = IW'((req_addr - BASE_ADDR) >> OFF);
  assign acc = req_valid & req_ready;
  assign wready = state == WRITE;
  assign done = state == DONE;
  assign wbeat = wready & wvalid;
  assign rbeat = rvalid & rready;
  assign last = (cnt + C1) == len;
`ifdef ADDR_RANGE_CHK_EN
  logic [ADDR_WIDTH:0] end_w;
  assign end_w = {1'b0, (req_addr - BASE_ADDR) >> OFF} + (ADDR_WIDTH+1)'(req_len);
  assign bad = (req_addr < BASE_ADDR) || (end_w > (ADDR_WIDTH+1)'(MEM_DEPTH));
  assign err = done & bad_q;
`else
  assign bad = 1'b0;
  assign err = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    if (acc) nxt = req_len == '0 ? DONE : req_write ? WRITE : READ;
    else if ((wbeat || rbeat) && last) nxt = DONE;
    else if (state == DONE) nxt = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      req_ready <= 1'b0;
      idx <= '0;
      cnt <= '0;
      len <= '0;
      bad_q <= 1'b0;
      rvalid <= 1'b0;
      rdata <= '0;
    end else begin
      req_ready <= nxt == IDLE;
      if (acc) begin
        idx <= start;
        cnt <= '0;
        len <= req_len;
        bad_q <= bad;
        if (!req_write && req_len != '0) begin
          rvalid <= 1'b1;
          rdata <= bad ? '0 : mem[start];
        end
      end
      if (wbeat) begin
        idx <= idx + I1;
        cnt <= cnt + C1;
      end
      if (rbeat) begin
        cnt <= cnt + C1;
        rvalid <= !last;
        if (!last) begin
          idx <= idx + I1;
          rdata <= bad_q ? '0 : mem[idx + I1];
        end
      end
    end
  // Memory is deliberately outside the reset domain so contents survive rst_n.
  always_ff @(posedge clk)
    if (wbeat && !bad_q) mem[idx] <= wdata;
endmodule
